// File: rtl/wb_periph_mux.sv
// wb_periph_mux: Wishbone classic decoder/mux fanning one slave port out to NS
// downstream slaves, plus a local register slot (interrupt aggregation, error log).
//
// Ports:
//   wb_clk_i, wb_rst_ni              clock, asynchronous active-low reset
//   wbs_cyc_i, wbs_stb_i, wbs_we_i   upstream Wishbone classic controls
//   wbs_sel_i, wbs_adr_i, wbs_dat_i  byte selects, address, write data
//   wbs_ack_o, wbs_dat_o             registered ack and read data
//   m_cyc_o, m_stb_o                 one-hot per-slave cycle/strobe (slaves share wbs_adr/dat/we/sel)
//   m_ack_i, m_dat_i                 per-slave ack and read data (slave i at bits 32i+31:32i)
//   irq_i, irq_o                     slave level interrupts, aggregated interrupt
module wb_periph_mux #(
    parameter int unsigned NS          = 4,
    parameter int unsigned DEC_LSB     = 16,
    parameter int unsigned DEC_W       = 4,
    parameter int unsigned SLOT_STRIDE = 2,
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [NS-1:0]      m_cyc_o,
    output logic [NS-1:0]      m_stb_o,
    input  logic [NS-1:0]      m_ack_i,
    input  logic [NS*32-1:0]   m_dat_i,
    input  logic [NS-1:0]      irq_i,
    output logic               irq_o
);
    localparam int unsigned KW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [2:0] {IDLE, FWD, REG, ERR, RESP} state_e;

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d, hit_k;
    logic              hit;
    logic [DEC_W-1:0]  field;
    logic [15:0]       wait_q, wait_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [31:0]       err_adr_q, err_adr_d;
    logic [NS-1:0]     mask_q, mask_d, pend_q, pend_d, prev_q, w1c;
    logic              ack_q, irq_q;
    logic [31:0]       dat_q, dat_d;
    logic              timeout, slv_ack, err_evt, reg_wr;
    logic [31:0]       slv_dat, reg_rd, resp_dat;
    logic [7:0]        off;
    logic              unused_bits;

    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:NS]};
    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign irq_o       = irq_q;

    // Slot match takes priority over the all-ones register window.
    always_comb begin
        field = wbs_adr_i[DEC_LSB +: DEC_W];
        hit   = 1'b0;
        hit_k = '0;
        for (int i = 0; i < NS; i++) begin
            if (32'(field) == i * SLOT_STRIDE) begin
                hit   = 1'b1;
                hit_k = KW'(i);
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Dropping cyc in any waiting state abandons the cycle without an ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wbs_cyc_i && wbs_stb_i) state_d = hit ? FWD : (&field ? REG : ERR);
            FWD:     state_d = !wbs_cyc_i ? IDLE : (slv_ack || timeout) ? RESP : FWD;
            REG,
            ERR:     state_d = !wbs_cyc_i ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_stb_o = '0;
        for (int i = 0; i < NS; i++) m_stb_o[i] = (state_q == FWD) && (k_q == KW'(i));
        m_cyc_o = m_stb_o;
    end

    always_comb begin
        slv_ack   = m_ack_i[k_q];
        slv_dat   = m_dat_i[32*k_q +: 32];
        off       = wbs_adr_i[7:0];
        timeout   = wait_q == 16'(TIMEOUT - 1);
        err_evt   = wbs_cyc_i && (state_q == ERR || (state_q == FWD && !slv_ack && timeout));
        reg_wr    = wbs_cyc_i && state_q == REG && wbs_we_i && wbs_sel_i[0];
        w1c       = (reg_wr && off == 8'h08) ? wbs_dat_i[NS-1:0] : '0;
        reg_rd    = off == 8'h00 ? 32'(irq_i) :
                    off == 8'h04 ? 32'(mask_q) :
                    off == 8'h08 ? 32'(pend_q) :
                    off == 8'h0C ? 32'(err_cnt_q) :
                    off == 8'h10 ? err_adr_q : 32'd0;
        resp_dat  = (state_q == FWD && slv_ack) ? slv_dat : (state_q == REG) ? reg_rd : ERR_DATA;
        dat_d     = (state_d == RESP) ? resp_dat : dat_q;
        k_d       = (state_q == IDLE) ? hit_k : k_q;
        wait_d    = (state_q == FWD) ? wait_q + 16'd1 : 16'd0;
        err_cnt_d = (reg_wr && off == 8'h0C) ? 16'd0 :
                    (err_evt && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
        err_adr_d = err_evt ? wbs_adr_i : err_adr_q;
        mask_d    = (reg_wr && off == 8'h04) ? wbs_dat_i[NS-1:0] : mask_q;
        // A rising edge seen in the same cycle as the clear keeps the bit set.
        pend_d    = (pend_q & ~w1c) | (irq_i & ~prev_q);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            k_q       <= '0;
            wait_q    <= '0;
            err_cnt_q <= '0;
            err_adr_q <= '0;
            mask_q    <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            k_q       <= k_d;
            wait_q    <= wait_d;
            err_cnt_q <= err_cnt_d;
            err_adr_q <= err_adr_d;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            prev_q    <= irq_i;
            ack_q     <= state_d == RESP;
            dat_q     <= dat_d;
            irq_q     <= |(pend_q & mask_q);
        end
    end
endmodule

// File: tb/tb_wb_periph_mux.sv
// tb_wb_periph_mux: randomized self-checking bench against a transaction-level model.
module tb_wb_periph_mux;
    localparam int NS = 4;
    localparam int TO = 8;
    localparam logic [31:0] ED = 32'hDEADBEEF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]      sel = 4'h0;
    logic [31:0]     adr = '0, wdat = '0;
    logic            ack;
    logic [31:0]     rdat;
    logic [NS-1:0]   m_cyc, m_stb;
    logic [NS-1:0]   m_ack = '0;
    logic [NS*32-1:0] m_dat = '0;
    logic [NS-1:0]   irq = '0;
    logic            irq_o;

    int n_tests = 0;
    int n_fail = 0;

    logic [3:0]  mdl_mask = '0, mdl_pend = '0, irq_lvl = '0;
    logic [15:0] mdl_cnt = '0;
    logic [31:0] mdl_adr = '0;
    logic [31:0] rd;
    bit          b2b = 1'b0;

    always #5 clk = ~clk;

    wb_periph_mux #(.NS(NS), .DEC_LSB(16), .DEC_W(4), .SLOT_STRIDE(2), .TIMEOUT(TO), .ERR_DATA(ED)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_ack_i(m_ack), .m_dat_i(m_dat),
        .irq_i(irq), .irq_o(irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_irq(input logic [3:0] v);
        @(negedge clk);
        mdl_pend = mdl_pend | (v & ~irq_lvl);
        irq      = v;
        irq_lvl  = v;
    endtask

    // One upstream transaction; the slave acks `lat` cycles after its strobe first appears.
    task automatic do_txn(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] s,
                          input int lat, input logic [3:0] irq_n1, input bit keep, output logic [31:0] r);
        int f, k, n, sn, exp_n, exp_sn, cyc_bad;
        bit slot, rg, got;
        logic [3:0] stb_or;
        logic [31:0] exp_d;
        logic [7:0] o;
        f = int'(a[19:16]);
        o = a[7:0];
        slot = (f % 2 == 0) && (f / 2 < NS);
        rg = (f == 15);
        k = slot ? f / 2 : 0;
        r = '0;
        @(negedge clk);
        for (int i = 0; i < NS; i++) m_dat[32*i +: 32] = $urandom;
        cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = d; sel = s;
        if (slot) begin
            exp_d  = (lat < TO) ? m_dat[32*k +: 32] : ED;
            exp_n  = (lat < TO) ? lat + 2 : TO + 1;
            exp_sn = (lat < TO) ? lat + 1 : TO;
        end else begin
            exp_n  = 2;
            exp_sn = 0;
            exp_d  = ED;
            if (rg) case (o)
                8'h00:   exp_d = {28'd0, irq_n1};
                8'h04:   exp_d = {28'd0, mdl_mask};
                8'h08:   exp_d = {28'd0, mdl_pend};
                8'h0C:   exp_d = {16'd0, mdl_cnt};
                8'h10:   exp_d = mdl_adr;
                default: exp_d = 32'd0;
            endcase
        end
        n = 0; sn = 0; got = 1'b0; stb_or = '0; cyc_bad = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) irq = irq_n1;
            if (m_cyc !== m_stb) cyc_bad++;
            stb_or = stb_or | m_stb;
            if (m_stb != 0) sn++;
            m_ack = ((m_stb != 0 && sn == lat + 1) ? m_stb : 4'b0) |
                    ((m_stb != 0) ? (4'($urandom) & ~m_stb) : 4'b0);
            if (ack) begin
                got = 1'b1;
                r = rdat;
            end
        end
        chk("ack_latency", n, exp_n);
        chk("stb_pattern", 32'(stb_or), slot ? 32'(1 << k) : 32'd0);
        chk("stb_cycles", sn, exp_sn);
        chk("cyc_eq_stb", cyc_bad, 0);
        if (!w) chk("read_data", r, exp_d);
        if (!keep) begin
            cyc = 1'b0; stb = 1'b0;
            @(negedge clk);
            chk("ack_one_cycle", 32'(ack), 0);
        end
        if ((slot && lat >= TO) || (!slot && !rg)) begin
            if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
            mdl_adr = a;
        end
        if (rg && w && s[0]) case (o)
            8'h04:   mdl_mask = d[3:0];
            8'h08:   mdl_pend = mdl_pend & ~d[3:0];
            8'h0C:   mdl_cnt = 16'd0;
            default: ;
        endcase
        mdl_pend = mdl_pend | (irq_n1 & ~irq_lvl);
        irq_lvl = irq_n1;
    endtask

    task automatic rd_reg(input logic [7:0] o, output logic [31:0] r);
        do_txn({24'h300F00, o}, 1'b0, 32'd0, 4'hF, 0, irq_lvl, 1'b0, r);
    endtask

    task automatic wr_reg(input logic [7:0] o, input logic [31:0] d, input logic [3:0] irq_n1);
        logic [31:0] r;
        do_txn({24'h300F00, o}, 1'b1, d, 4'hF, 0, irq_n1, 1'b0, r);
    endtask

    initial begin
        int acks, f, lat;
        logic [31:0] a;
        logic [7:0] offs [6];
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dat", rdat, 0);
        chk("rst_stb", 32'(m_stb), 0);
        chk("rst_cyc", 32'(m_cyc), 0);
        chk("rst_irq", 32'(irq_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(32'h3002_0000, 1'b0, 32'd0, 4'hF, 3, irq_lvl, 1'b0, rd);
        do_txn(32'h3006_0000, 1'b0, 32'd0, 4'hF, 1000, irq_lvl, 1'b0, rd);
        chk("timeout_data", rd, ED);
        rd_reg(8'h0C, rd);
        chk("err_cnt_one", rd, 32'd1);
        rd_reg(8'h10, rd);
        chk("err_adr", rd, 32'h3006_0000);
        do_txn(32'h3005_0000, 1'b0, 32'd0, 4'hF, 0, irq_lvl, 1'b0, rd);
        chk("odd_slot_data", rd, ED);

        wr_reg(8'h04, 32'h5, irq_lvl);
        set_irq(4'h4);
        repeat (2) @(negedge clk);
        chk("irq_o_rise", 32'(irq_o), 1);
        set_irq(4'h0);
        @(negedge clk);
        wr_reg(8'h08, 32'h4, 4'h4);
        rd_reg(8'h08, rd);
        chk("pend_set_wins", 32'(rd[2]), 1);
        wr_reg(8'h08, 32'h4, irq_lvl);
        rd_reg(8'h08, rd);
        chk("pend_cleared", 32'(rd[2]), 0);
        wr_reg(8'h04, 32'hF, irq_lvl);
        do_txn(32'h300F_0004, 1'b1, 32'h0, 4'hE, 0, irq_lvl, 1'b0, rd);
        rd_reg(8'h04, rd);
        chk("sel0_ignored", rd, 32'hF);

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = 32'h3004_0000; we = 1'b0; m_ack = '0;
        repeat (3) @(negedge clk);
        chk("abort_stb_pre", 32'(m_stb), 32'h4);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("abort_stb_drop", 32'(m_stb), 0);
        acks = 0;
        repeat (4) begin
            if (ack) acks++;
            @(negedge clk);
        end
        chk("abort_no_ack", acks, 0);
        rd_reg(8'h0C, rd);
        chk("abort_cnt", rd, {16'd0, mdl_cnt});

        force dut.err_cnt_q = 16'hFFFE;
        repeat (2) @(negedge clk);
        release dut.err_cnt_q;
        mdl_cnt = 16'hFFFE;
        do_txn(32'h3009_0000, 1'b0, 32'd0, 4'hF, 0, irq_lvl, 1'b0, rd);
        do_txn(32'h300B_0000, 1'b1, 32'd7, 4'hF, 0, irq_lvl, 1'b0, rd);
        rd_reg(8'h0C, rd);
        chk("cnt_saturated", rd, 32'h0000_FFFF);
        wr_reg(8'h0C, 32'h0, irq_lvl);
        rd_reg(8'h0C, rd);
        chk("cnt_cleared", rd, 32'd0);

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = 32'h3006_0000; we = 1'b0; m_ack = '0;
        repeat (3) @(negedge clk);
        chk("rst_pre_stb", 32'(m_stb), 32'h8);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_stb", 32'(m_stb), 0);
        chk("rst_mid_ack", 32'(ack), 0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_mask = '0; mdl_pend = irq_lvl; mdl_cnt = '0; mdl_adr = '0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("rst_no_ack", acks, 0);
        rd_reg(8'h0C, rd);
        chk("rst_cnt", rd, 32'd0);

        for (int t = 0; t < 160; t++) begin
            if (!b2b) begin
                if ($urandom_range(0, 3) == 0) set_irq(4'($urandom));
                repeat (2) @(negedge clk);
                chk("irq_o", 32'(irq_o), 32'(|(mdl_pend & mdl_mask)));
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: f = 2 * $urandom_range(0, NS - 1);
                5, 6:          f = 15;
                default: begin
                    f = $urandom_range(0, 14);
                    if (f % 2 == 0 && f / 2 < NS) f = f + 1;
                end
            endcase
            a = $urandom;
            a[19:16] = 4'(f);
            if (f == 15) a[7:0] = ($urandom_range(0, 6) == 6) ? 8'($urandom) : offs[$urandom_range(0, 5)];
            lat = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 6);
            b2b = $urandom_range(0, 3) == 0;
            do_txn(a, 1'($urandom), $urandom, 4'($urandom), lat, irq_lvl, b2b, rd);
        end
        if (b2b) begin
            cyc = 1'b0; stb = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("irq_o_final", 32'(irq_o), 32'(|(mdl_pend & mdl_mask)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
